// File: rtl/gb_stream_master_pkg.sv
// Shared command/reply codes, FSM state encoding and opcode helper for the ghostbus stream master.
package gb_stream_master_pkg;

  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_RD   = 8'h02;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // Wide enough for byte counts and any practical read delay.
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WSTB  = 3'd3,
    ST_RSTB  = 3'd4,
    ST_RWAIT = 3'd5,
    ST_RESP  = 3'd6
  } state_e;

  function automatic logic is_cmd_op(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/gb_stream_master_if.sv
// Command stream, reply stream and ghostbus signals of the stream master, grouped in one bundle.
interface gb_stream_master_if #(
  parameter int AW = 24,
  parameter int DW = 32
);

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout;
  logic [DW-1:0] gb_din;
  logic          gb_we;
  logic          gb_wstb;
  logic          gb_rstb;

  modport master (
    input  in_data, in_valid, out_ready, gb_din,
    output in_ready, out_data, out_valid, gb_addr, gb_dout, gb_we, gb_wstb, gb_rstb
  );

  modport slave (
    output in_data, in_valid, out_ready, gb_din,
    input  in_ready, out_data, out_valid, gb_addr, gb_dout, gb_we, gb_wstb, gb_rstb
  );

endinterface

// File: rtl/gb_stream_master.sv
// Byte-stream to ghostbus bridge: parses OP/address/data frames, issues one strobe per frame
// and serializes an ACK, NAK or read data back on the reply stream.
module gb_stream_master
  import gb_stream_master_pkg::*;
#(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int READ_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  gb_stream_master_if.master bus
);

  localparam int ABYTES = AW / 8;
  localparam int DBYTES = DW / 8;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_rd_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    dout_q;
  logic [DW-1:0]    resp_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             wstb_q;
  logic             rstb_q;

  logic [AW-1:0]    addr_d;
  logic [DW-1:0]    dout_d;
  logic [DW-1:0]    resp_shift_d;
  logic             accept_s;
  logic             handshake_s;
  logic             last_addr_s;
  logic             last_data_s;
  logic             last_resp_s;
  logic             rd_due_s;

  assign addr_d       = AW'({addr_q, bus.in_data});
  assign dout_d       = DW'({dout_q, bus.in_data});
  assign resp_shift_d = DW'({resp_q, 8'h00});
  assign accept_s     = in_ready_q & bus.in_valid;
  assign handshake_s  = out_valid_q & bus.out_ready;
  assign last_addr_s  = (cnt_q == CNT_W'(ABYTES - 1));
  assign last_data_s  = (cnt_q == CNT_W'(DBYTES - 1));
  // ACK and NAK replies are a single byte; only read data spans DBYTES.
  assign last_resp_s  = !is_rd_q || (cnt_q == CNT_W'(DBYTES - 1));
  assign rd_due_s     = (cnt_q == CNT_W'(READ_DELAY - 1));

  // Frame parser, strobe generator, read-delay counter and reply serializer in one state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      resp_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      wstb_q      <= 1'b0;
      rstb_q      <= 1'b0;
    end else begin
      wstb_q <= 1'b0;
      rstb_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            cnt_q <= '0;
            if (is_cmd_op(bus.in_data)) begin
              is_rd_q <= (bus.in_data == OP_RD);
              state_q <= ST_ADDR;
            end else begin
              is_rd_q     <= 1'b0;
              resp_q      <= DW'(RSP_NAK) << (DW - 8);
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (accept_s) begin
            addr_q <= addr_d;
            if (last_addr_s) begin
              cnt_q <= '0;
              if (is_rd_q) begin
                rstb_q     <= 1'b1;
                in_ready_q <= 1'b0;
                state_q    <= ST_RSTB;
              end else begin
                state_q <= ST_WDATA;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WDATA: begin
          if (accept_s) begin
            dout_q <= dout_d;
            if (last_data_s) begin
              cnt_q      <= '0;
              wstb_q     <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= ST_WSTB;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WSTB: begin
          resp_q      <= DW'(RSP_ACK) << (DW - 8);
          out_valid_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ST_RESP;
        end
        ST_RSTB: begin
          cnt_q   <= '0;
          state_q <= ST_RWAIT;
        end
        ST_RWAIT: begin
          if (rd_due_s) begin
            resp_q      <= bus.gb_din;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (handshake_s) begin
            if (last_resp_s) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_IDLE;
            end else begin
              resp_q <= resp_shift_d;
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = resp_q[DW-1 -: 8];
  assign bus.gb_addr   = addr_q;
  assign bus.gb_dout   = dout_q;
  assign bus.gb_we     = wstb_q;
  assign bus.gb_wstb   = wstb_q;
  assign bus.gb_rstb   = rstb_q;

endmodule
